// File: rtl/mcs4_timing_pkg.sv
// Shared timing definitions for the MCS-4 clock controller: phase and state
// encodings plus the default 4004 clock-period shape in sysclk ticks.
package mcs4_timing_pkg;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        ST_POC,
        ST_RUN,
        ST_HALTING,
        ST_HALTED,
        ST_STEP
    } state_e;

    localparam int DEF_PERIOD     = 68;
    localparam int DEF_CLK1_W     = 19;
    localparam int DEF_CLK2_START = 34;
    localparam int DEF_CLK2_W     = 19;
    localparam int DEF_POC_CYCLES = 64;

endpackage

// File: rtl/mcs4_clock_controller_if.sv
// Board-side signal bundle of the clock controller: run/step/sync in,
// two-phase clocks, power-on clear and status out.
interface mcs4_clock_controller_if;

    logic        run;
    logic        step;
    logic        sync;
    logic        clk1_pad;
    logic        clk2_pad;
    logic        poc_pad;
    logic [2:0]  phase;
    logic        halted;
    logic        sync_err;
    logic [15:0] instr_count;

    modport master (
        input  run, step, sync,
        output clk1_pad, clk2_pad, poc_pad, phase, halted, sync_err, instr_count
    );

    modport slave (
        output run, step, sync,
        input  clk1_pad, clk2_pad, poc_pad, phase, halted, sync_err, instr_count
    );

endinterface

// File: rtl/mcs4_twophase_gen.sv
// Period tick counter with hold/restart and registered non-overlapping
// clk1/clk2 decodes; at_end flags the last tick of a period.
module mcs4_twophase_gen #(
    parameter int PERIOD     = 68,
    parameter int CLK1_W     = 19,
    parameter int CLK2_START = 34,
    parameter int CLK2_W     = 19
) (
    input  logic sysclk,
    input  logic reset,
    input  logic advance,
    input  logic restart,
    output logic clk1,
    output logic clk2,
    output logic at_end
);

    localparam int                TC_W    = $clog2(PERIOD);
    localparam logic [TC_W-1:0]   TC_LAST = TC_W'(PERIOD - 1);

    logic [TC_W-1:0] tc_q, tc_d;
    logic            clk1_q, clk1_d;
    logic            clk2_q, clk2_d;

    always_comb begin
        tc_d = tc_q;
        if (restart) begin
            tc_d = '0;
        end else if (advance) begin
            tc_d = (tc_q == TC_LAST) ? '0 : tc_q + TC_W'(1);
        end
        // A held counter parks on TC_LAST, which decodes to both clocks low.
        clk1_d = (int'(tc_q) < CLK1_W);
        clk2_d = (int'(tc_q) >= CLK2_START) && (int'(tc_q) < CLK2_START + CLK2_W);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tc_q   <= '0;
            clk1_q <= 1'b0;
            clk2_q <= 1'b0;
        end else begin
            tc_q   <= tc_d;
            clk1_q <= clk1_d;
            clk2_q <= clk2_d;
        end
    end

    assign clk1   = clk1_q;
    assign clk2   = clk2_q;
    assign at_end = (tc_q == TC_LAST);

endmodule

// File: rtl/mcs4_clock_controller.sv
// MCS-4 clock controller: run/halt/step sequencing, 8-phase tracking with
// sync resynchronisation, power-on clear and instruction-cycle counting.
import mcs4_timing_pkg::*;

module mcs4_clock_controller #(
    parameter int PERIOD     = DEF_PERIOD,
    parameter int CLK1_W     = DEF_CLK1_W,
    parameter int CLK2_START = DEF_CLK2_START,
    parameter int CLK2_W     = DEF_CLK2_W,
    parameter int POC_CYCLES = DEF_POC_CYCLES
) (
    input  logic                     sysclk,
    input  logic                     reset,
    mcs4_clock_controller_if.master  bus
);

    localparam int              PC_W    = $clog2(POC_CYCLES + 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(POC_CYCLES - 1);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d, nxt_phase;
    logic             poc_q, poc_d;
    logic [PC_W-1:0]  poc_cnt_q, poc_cnt_d;
    logic             halted_q, halted_d;
    logic             sync_err_q, sync_err_d;
    logic [15:0]      instr_count_q, instr_count_d;
    logic             running, advance, restart, hold, boundary, at_end;
    logic             clk1, clk2;

    mcs4_twophase_gen #(
        .PERIOD     (PERIOD),
        .CLK1_W     (CLK1_W),
        .CLK2_START (CLK2_START),
        .CLK2_W     (CLK2_W)
    ) u_gen (
        .sysclk  (sysclk),
        .reset   (reset),
        .advance (advance),
        .restart (restart),
        .clk1    (clk1),
        .clk2    (clk2),
        .at_end  (at_end)
    );

    assign running = (state_q != ST_HALTED);
    assign advance = running && !hold;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        poc_d         = poc_q;
        poc_cnt_d     = poc_cnt_q;
        halted_d      = halted_q;
        sync_err_d    = sync_err_q;
        instr_count_d = instr_count_q;
        restart       = 1'b0;
        hold          = 1'b0;
        boundary      = running && at_end;
        nxt_phase     = bus.sync ? PH_A1 : phase_e'(phase_q + 3'd1);

        if (boundary) begin
            phase_d = nxt_phase;
            if (bus.sync && (phase_q != PH_X3)) sync_err_d = 1'b1;
            if (nxt_phase == PH_A1) instr_count_d = instr_count_q + 16'd1;
        end

        unique case (state_q)
            ST_POC: begin
                if (boundary) begin
                    if (poc_cnt_q == PC_LAST) begin
                        poc_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        poc_cnt_d = poc_cnt_q + PC_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!bus.run) state_d = ST_HALTING;
            end
            ST_HALTING, ST_STEP: begin
                // Stop only on the boundary into A1; the counter parks on its
                // last tick so both clocks are already low and no pulse is cut.
                if (bus.run) begin
                    state_d = ST_RUN;
                end else if (boundary && (nxt_phase == PH_A1)) begin
                    hold     = 1'b1;
                    phase_d  = PH_X3;
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (bus.run || bus.step) begin
                    state_d  = bus.run ? ST_RUN : ST_STEP;
                    restart  = 1'b1;
                    phase_d  = PH_A1;
                    halted_d = 1'b0;
                end
            end
            default: state_d = ST_POC;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_POC;
            phase_q       <= PH_X3;
            poc_q         <= 1'b1;
            poc_cnt_q     <= '0;
            halted_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            poc_q         <= poc_d;
            poc_cnt_q     <= poc_cnt_d;
            halted_q      <= halted_d;
            sync_err_q    <= sync_err_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.clk1_pad    = clk1;
    assign bus.clk2_pad    = clk2;
    assign bus.poc_pad     = poc_q;
    assign bus.phase       = phase_q;
    assign bus.halted      = halted_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_mcs4_clock_controller.sv
// Bench for mcs4_clock_controller: behavioural reference model feeding an
// expectation queue, a negedge monitor, and directed plus random sequences.
module tb_mcs4_clock_controller;

    localparam int PERIOD     = 68;
    localparam int CLK1_W     = 19;
    localparam int CLK2_START = 34;
    localparam int CLK2_W     = 19;
    localparam int POC_CYCLES = 64;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;

    mcs4_clock_controller_if bus();

    mcs4_clock_controller #(
        .PERIOD     (PERIOD),
        .CLK1_W     (CLK1_W),
        .CLK2_START (CLK2_START),
        .CLK2_W     (CLK2_W),
        .POC_CYCLES (POC_CYCLES)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;
    int sb_fail = 0;
    bit sb_on = 1'b1;
    logic [23:0] exp_q[$];

    // Reference model state, expressed as plain counters and flags.
    int          m_tick, m_ph, m_periods, m_nph;
    bit          m_frozen, m_poc, m_armed, m_hlt, m_err, m_c1, m_c2, m_end, m_stop;
    logic [15:0] m_cnt;

    bit sync_ovr = 1'b0;
    bit sync_val = 1'b0;

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_tick = 0; m_ph = 7; m_periods = 0; m_cnt = 16'd0;
            m_frozen = 0; m_poc = 1; m_armed = 0; m_hlt = 0; m_err = 0;
            m_c1 = 0; m_c2 = 0;
            exp_q.delete();
        end else begin
            m_c1 = (m_tick < CLK1_W);
            m_c2 = (m_tick >= CLK2_START) && (m_tick < CLK2_START + CLK2_W);
            if (m_frozen) begin
                if (bus.run || bus.step) begin
                    m_frozen = 0; m_hlt = 0; m_tick = 0; m_ph = 0;
                    m_armed = !bus.run;
                end
            end else begin
                m_end  = (m_tick == PERIOD - 1);
                m_nph  = bus.sync ? 0 : (m_ph + 1) % 8;
                m_stop = 0;
                if (m_end) begin
                    if (bus.sync && m_ph != 7) m_err = 1;
                    if (m_nph == 0) m_cnt = m_cnt + 16'd1;
                    m_ph = m_nph;
                end
                if (m_poc) begin
                    if (m_end) begin
                        m_periods++;
                        if (m_periods == POC_CYCLES) m_poc = 0;
                    end
                end else if (!m_armed) begin
                    if (!bus.run) m_armed = 1;
                end else if (bus.run) begin
                    m_armed = 0;
                end else if (m_end && m_nph == 0) begin
                    m_stop = 1; m_frozen = 1; m_hlt = 1; m_ph = 7; m_armed = 0;
                end
                if (!m_stop) m_tick = m_end ? 0 : m_tick + 1;
            end
        end
        exp_q.push_back({m_c1, m_c2, m_poc, 3'(m_ph), m_hlt, m_err, m_cnt});
    end

    // CPU sync stand-in: high through X3 (occasionally omitted), or overridden.
    always @(negedge sysclk) begin
        if (sync_ovr) bus.sync = sync_val;
        else          bus.sync = (m_ph == 7) && !m_frozen && ($urandom_range(0, 7) != 0);
    end

    always @(negedge sysclk) begin
        logic [23:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.clk1_pad, bus.clk2_pad, bus.poc_pad, bus.phase,
                 bus.halted, bus.sync_err, bus.instr_count};
            if (sb_on) begin
                total++;
                if (a !== e) begin
                    bad++;
                    sb_fail++;
                    $display("FAIL scoreboard t=%0t: got %h expected %h", $time, a, e);
                    if (sb_fail >= 20) sb_on = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_phase(input int p, input string name);
        int g = 0;
        while (bus.phase != 3'(p) && g < 10 * PERIOD) begin @(negedge sysclk); g++; end
        chk(name, g < 10 * PERIOD, 1);
    endtask

    task automatic wait_halted(input logic v, input string name, output int rises);
        int g = 0;
        logic prev = bus.clk1_pad;
        rises = 0;
        while (bus.halted !== v && g < 12 * PERIOD) begin
            @(negedge sysclk);
            if (bus.clk1_pad && !prev) rises++;
            prev = bus.clk1_pad;
            g++;
        end
        chk(name, g < 12 * PERIOD, 1);
    endtask

    task automatic measure(output int h1, output int g12, output int h2, output int g21);
        int g = 0;
        while (bus.clk1_pad && g < 2 * PERIOD) begin @(negedge sysclk); g++; end
        while (!bus.clk1_pad && g < 4 * PERIOD) begin @(negedge sysclk); g++; end
        h1 = 0;  while (bus.clk1_pad  && h1  < 2 * PERIOD) begin @(negedge sysclk); h1++;  end
        g12 = 0; while (!bus.clk2_pad && g12 < 2 * PERIOD) begin @(negedge sysclk); g12++; end
        h2 = 0;  while (bus.clk2_pad  && h2  < 2 * PERIOD) begin @(negedge sysclk); h2++;  end
        g21 = 0; while (!bus.clk1_pad && g21 < 2 * PERIOD) begin @(negedge sysclk); g21++; end
    endtask

    task automatic pulse_step();
        @(negedge sysclk); bus.step = 1'b1;
        @(negedge sysclk); bus.step = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sysclk); reset = 1'b1;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
    endtask

    initial begin
        int n, cyc, h1, g12, h2, g21, errs, prev_ph, c0, rises, hl;
        logic prev;
        bus.run = 1'b1; bus.step = 1'b0;
        #2 reset = 1'b1;
        #1 chk("reset_poc", bus.poc_pad, 1);
        chk("reset_phase", bus.phase, 7);
        chk("reset_clocks", {bus.clk1_pad, bus.clk2_pad}, 0);
        repeat (3) @(negedge sysclk);
        reset = 1'b0;

        // Power-on clear length and free-run waveform.
        n = 0; cyc = 0; prev = 1'b0;
        while (bus.poc_pad && cyc < 70 * PERIOD) begin
            @(negedge sysclk);
            if (bus.clk1_pad && !prev) n++;
            prev = bus.clk1_pad;
            cyc++;
        end
        chk("poc_clk1_pulses", n, POC_CYCLES);
        chk("poc_cycles", cyc, POC_CYCLES * PERIOD);
        measure(h1, g12, h2, g21);
        chk("clk1_width", h1, CLK1_W);
        chk("gap_1_2", g12, CLK2_START - CLK1_W);
        chk("clk2_width", h2, CLK2_W);
        chk("gap_2_1", g21, PERIOD - CLK2_START - CLK2_W);
        errs = 0; prev_ph = bus.phase;
        for (int i = 0; i < 16 * PERIOD; i++) begin
            @(negedge sysclk);
            if (bus.phase != 3'(prev_ph)) begin
                if (int'(bus.phase) != (prev_ph + 1) % 8) errs++;
                prev_ph = bus.phase;
            end
        end
        chk("phase_sequence_errs", errs, 0);
        chk("no_sync_err", bus.sync_err, 0);

        // Halt requested mid-instruction.
        wait_phase(3, "wait_m1");
        c0 = bus.instr_count;
        bus.run = 1'b0;
        wait_halted(1'b1, "halt_timeout", rises);
        chk("halt_phase", bus.phase, 7);
        chk("halt_clocks_low", {bus.clk1_pad, bus.clk2_pad}, 0);
        chk("halt_count", bus.instr_count, 16'(c0 + 1));
        n = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin @(negedge sysclk); if (bus.clk1_pad) n++; end
        chk("halted_no_clk1", n, 0);

        // Single-instruction steps.
        c0 = bus.instr_count;
        for (int k = 0; k < 3; k++) begin
            pulse_step();
            chk("step_left_halt", bus.halted, 0);
            wait_halted(1'b1, "step_timeout", rises);
            chk("step_clk1_pulses", rises, 8);
        end
        chk("step_count", bus.instr_count, 16'(c0 + 3));

        // Out-of-place sync.
        @(negedge sysclk); bus.run = 1'b1;
        wait_phase(4, "wait_m2");
        c0 = bus.instr_count;
        sync_val = 1'b1; sync_ovr = 1'b1;
        n = 0;
        while (bus.phase == 3'd4 && n < 2 * PERIOD) begin @(negedge sysclk); n++; end
        sync_ovr = 1'b0;
        chk("resync_phase", bus.phase, 0);
        chk("sync_err_set", bus.sync_err, 1);
        chk("resync_count", bus.instr_count, 16'(c0 + 1));
        repeat (3 * PERIOD) @(negedge sysclk);
        chk("sync_err_sticky", bus.sync_err, 1);

        // run and step together, then run=0 held through power-on clear.
        bus.run = 1'b0;
        wait_halted(1'b1, "halt2_timeout", rises);
        @(negedge sysclk); bus.run = 1'b1; bus.step = 1'b1;
        @(negedge sysclk); bus.step = 1'b0;
        n = 0; hl = 0; prev = bus.clk1_pad;
        for (int i = 0; i < 20 * PERIOD; i++) begin
            @(negedge sysclk);
            if (bus.clk1_pad && !prev) n++;
            if (bus.halted) hl++;
            prev = bus.clk1_pad;
        end
        chk("runstep_no_halt", hl, 0);
        chk("runstep_continuous", n >= 19, 1);
        bus.run = 1'b0;
        do_reset();
        hl = 0; cyc = 0;
        while (bus.poc_pad && cyc < 70 * PERIOD) begin
            @(negedge sysclk); if (bus.halted) hl++; cyc++;
        end
        chk("poc_ignores_run", hl, 0);
        wait_halted(1'b1, "post_poc_halt", rises);

        // Asynchronous reset while clk2 is high.
        @(negedge sysclk); bus.run = 1'b1;
        n = 0;
        while (!bus.clk2_pad && n < 4 * PERIOD) begin @(negedge sysclk); n++; end
        chk("clk2_seen", bus.clk2_pad, 1);
        @(posedge sysclk); #3 reset = 1'b1;
        #1 chk("rst_clk2_low", bus.clk2_pad, 0);
        chk("rst_poc", bus.poc_pad, 1);
        chk("rst_count", bus.instr_count, 0);
        @(negedge sysclk); @(negedge sysclk);
        bus.run = 1'b0;
        reset = 1'b0;

        // Counter wrap at 0xFFFF.
        n = 0;
        while (!bus.halted && n < 80 * PERIOD) begin @(negedge sysclk); n++; end
        chk("wrap_halt_reached", bus.halted, 1);
        #2 force dut.instr_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(negedge sysclk); #2 release dut.instr_count_q;
        repeat (3) @(negedge sysclk);
        chk("wrap_preload", bus.instr_count, 16'hFFFF);
        pulse_step();
        wait_halted(1'b1, "wrap_step", rises);
        chk("wrap_zero", bus.instr_count, 0);

        // Random run/step/sync activity, checked by the scoreboard.
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 300)) @(negedge sysclk);
            case ($urandom_range(0, 3))
                0: bus.run = ~bus.run;
                1: pulse_step();
                2: begin
                    sync_val = 1'b1; sync_ovr = 1'b1;
                    repeat ($urandom_range(1, 100)) @(negedge sysclk);
                    sync_ovr = 1'b0;
                end
                default: begin
                    sync_val = 1'b0; sync_ovr = 1'b1;
                    repeat ($urandom_range(1, 150)) @(negedge sysclk);
                    sync_ovr = 1'b0;
                end
            endcase
        end
        repeat (20) @(negedge sysclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
